// File: rtl/ln_stat_calc_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ln_stat_calc_pipe
// Description : LayerNorm row statistics; mean and saturated variance from
//               sum / sum-of-squares with a per-row reciprocal, valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module ln_stat_calc_pipe #(
    parameter int          SUM_W      = 31,
    parameter int          SQ_W       = 51,
    parameter int          RECIP_W    = 12,
    parameter int          RECIP_SH   = 20,
    parameter int          MEAN_W     = 32,
    parameter int          VAR_W      = 16,
    parameter int          TAG_W      = 2,
    parameter int unsigned EPS        = 0,
    parameter int          MUL_STAGES = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic signed [SUM_W-1:0]  i_sum,
    input  logic signed [SQ_W-1:0]   i_sq_sum,
    input  logic [RECIP_W-1:0]       i_recip,
    input  logic [TAG_W-1:0]         i_bank_id,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic signed [MEAN_W-1:0] o_mean,
    output logic [VAR_W-1:0]         o_variance,
    output logic                     o_var_zero,
    output logic                     o_var_sat,
    output logic [TAG_W-1:0]         o_bank_id,
    output logic                     o_busy
);

    localparam int c_PS_W  = SUM_W + RECIP_W + 1;
    localparam int c_PQ_W  = SQ_W + RECIP_W + 1;
    localparam int c_MSQ_W = 2 * c_PS_W;
    localparam int c_RAW_W = ((c_MSQ_W > c_PQ_W) ? c_MSQ_W : c_PQ_W) + 2;
    localparam int c_L     = MUL_STAGES - 1;

    logic w_en;
    assign w_en    = ~o_valid | i_ready;
    assign o_ready = w_en;

    // Operand stage: first multiplier register
    logic                     op_vld_q;
    logic signed [SUM_W-1:0]  op_sum_q;
    logic signed [SQ_W-1:0]   op_sq_q;
    logic [RECIP_W-1:0]       op_recip_q;
    logic [TAG_W-1:0]         op_tag_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)     op_vld_q <= 1'b0;
        else if (w_en) op_vld_q <= i_valid;
    end

    always_ff @(posedge i_clk) begin
        if (w_en) begin
            op_sum_q   <= i_sum;
            op_sq_q    <= i_sq_sum;
            op_recip_q <= i_recip;
            op_tag_q   <= i_bank_id;
        end
    end

    logic signed [c_PS_W-1:0] w_prod_sum;
    logic signed [c_PQ_W-1:0] w_prod_sq;
    assign w_prod_sum = c_PS_W'(op_sum_q) * $signed(c_PS_W'(op_recip_q));
    assign w_prod_sq  = c_PQ_W'(op_sq_q)  * $signed(c_PQ_W'(op_recip_q));

    logic                     w_mul_vld;
    logic signed [c_PS_W-1:0] w_mul_sum;
    logic signed [c_PQ_W-1:0] w_mul_sq;
    logic [TAG_W-1:0]         w_mul_tag;
    logic                     w_mul_busy;

    generate
        if (MUL_STAGES > 1) begin : g_mul_pipe
            logic [MUL_STAGES-2:0]    mp_vld_q;
            logic signed [c_PS_W-1:0] mp_sum_q [MUL_STAGES-1];
            logic signed [c_PQ_W-1:0] mp_sq_q  [MUL_STAGES-1];
            logic [TAG_W-1:0]         mp_tag_q [MUL_STAGES-1];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    mp_vld_q <= '0;
                end else if (w_en) begin
                    mp_vld_q[0] <= op_vld_q;
                    for (int k = 1; k < MUL_STAGES - 1; k++) mp_vld_q[k] <= mp_vld_q[k-1];
                end
            end

            always_ff @(posedge i_clk) begin
                if (w_en) begin
                    mp_sum_q[0] <= w_prod_sum;
                    mp_sq_q[0]  <= w_prod_sq;
                    mp_tag_q[0] <= op_tag_q;
                    for (int k = 1; k < MUL_STAGES - 1; k++) begin
                        mp_sum_q[k] <= mp_sum_q[k-1];
                        mp_sq_q[k]  <= mp_sq_q[k-1];
                        mp_tag_q[k] <= mp_tag_q[k-1];
                    end
                end
            end

            assign w_mul_vld  = mp_vld_q[MUL_STAGES-2];
            assign w_mul_sum  = mp_sum_q[MUL_STAGES-2];
            assign w_mul_sq   = mp_sq_q[MUL_STAGES-2];
            assign w_mul_tag  = mp_tag_q[MUL_STAGES-2];
            assign w_mul_busy = |mp_vld_q;
        end else begin : g_mul_direct
            assign w_mul_vld  = op_vld_q;
            assign w_mul_sum  = w_prod_sum;
            assign w_mul_sq   = w_prod_sq;
            assign w_mul_tag  = op_tag_q;
            assign w_mul_busy = 1'b0;
        end
    endgenerate

    // Shift stage: arithmetic shift floors toward minus infinity
    logic                     sh_vld_q;
    logic signed [c_PS_W-1:0] sh_mean_q;
    logic signed [c_PQ_W-1:0] sh_ex2_q;
    logic [TAG_W-1:0]         sh_tag_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)     sh_vld_q <= 1'b0;
        else if (w_en) sh_vld_q <= w_mul_vld;
    end

    always_ff @(posedge i_clk) begin
        if (w_en) begin
            sh_mean_q <= w_mul_sum >>> RECIP_SH;
            sh_ex2_q  <= w_mul_sq >>> RECIP_SH;
            sh_tag_q  <= w_mul_tag;
        end
    end

    logic signed [c_MSQ_W-1:0] w_msq;
    assign w_msq = c_MSQ_W'(sh_mean_q) * c_MSQ_W'(sh_mean_q);

    logic [MUL_STAGES-1:0]     sq_vld_q;
    logic signed [c_MSQ_W-1:0] sq_msq_q  [MUL_STAGES];
    logic signed [c_PQ_W-1:0]  sq_ex2_q  [MUL_STAGES];
    logic signed [MEAN_W-1:0]  sq_mean_q [MUL_STAGES];
    logic [TAG_W-1:0]          sq_tag_q  [MUL_STAGES];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sq_vld_q <= '0;
        end else if (w_en) begin
            sq_vld_q[0] <= sh_vld_q;
            for (int k = 1; k < MUL_STAGES; k++) sq_vld_q[k] <= sq_vld_q[k-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_en) begin
            sq_msq_q[0]  <= w_msq;
            sq_ex2_q[0]  <= sh_ex2_q;
            sq_mean_q[0] <= MEAN_W'(sh_mean_q);
            sq_tag_q[0]  <= sh_tag_q;
            for (int k = 1; k < MUL_STAGES; k++) begin
                sq_msq_q[k]  <= sq_msq_q[k-1];
                sq_ex2_q[k]  <= sq_ex2_q[k-1];
                sq_mean_q[k] <= sq_mean_q[k-1];
                sq_tag_q[k]  <= sq_tag_q[k-1];
            end
        end
    end

    logic signed [c_RAW_W-1:0] w_raw;
    logic                      w_neg;
    logic                      w_over;
    assign w_raw  = c_RAW_W'(sq_ex2_q[c_L]) - c_RAW_W'(sq_msq_q[c_L]) + $signed(c_RAW_W'(EPS));
    assign w_neg  = w_raw[c_RAW_W-1];
    assign w_over = |w_raw[c_RAW_W-2:VAR_W];

    logic                     st_vld_q;
    logic signed [MEAN_W-1:0] st_mean_q;
    logic [VAR_W-1:0]         st_var_q;
    logic                     st_zero_q;
    logic                     st_sat_q;
    logic [TAG_W-1:0]         st_tag_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)     st_vld_q <= 1'b0;
        else if (w_en) st_vld_q <= sq_vld_q[c_L];
    end

    always_ff @(posedge i_clk) begin
        if (w_en) begin
            st_mean_q <= sq_mean_q[c_L];
            st_var_q  <= w_neg ? '0 : (w_over ? '1 : w_raw[VAR_W-1:0]);
            st_zero_q <= w_neg;
            st_sat_q  <= ~w_neg & w_over;
            st_tag_q  <= sq_tag_q[c_L];
        end
    end

    // Bubbles load zeros so no stale row data is ever visible on the outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_mean     <= '0;
            o_variance <= '0;
            o_var_zero <= 1'b0;
            o_var_sat  <= 1'b0;
            o_bank_id  <= '0;
        end else if (w_en) begin
            o_valid    <= st_vld_q;
            o_mean     <= st_vld_q ? st_mean_q : '0;
            o_variance <= st_vld_q ? st_var_q  : '0;
            o_var_zero <= st_vld_q & st_zero_q;
            o_var_sat  <= st_vld_q & st_sat_q;
            o_bank_id  <= st_vld_q ? st_tag_q  : '0;
        end
    end

    assign o_busy = op_vld_q | w_mul_busy | sh_vld_q | (|sq_vld_q) | st_vld_q | o_valid;

endmodule
`default_nettype wire

// File: tb/tb_ln_stat_calc_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ln_stat_calc_pipe
// Description : Directed self-checking bench for ln_stat_calc_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ln_stat_calc_pipe;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_valid;
    logic signed [30:0] i_sum;
    logic signed [50:0] i_sq_sum;
    logic [11:0]        i_recip;
    logic [1:0]         i_bank_id;
    logic               i_ready;

    logic               o_ready, o_valid, o_var_zero, o_var_sat, o_busy;
    logic signed [31:0] o_mean;
    logic [15:0]        o_variance;
    logic [1:0]         o_bank_id;

    logic               e1_ready, e1_valid, e1_zero, e1_sat, e1_busy;
    logic signed [31:0] e1_mean;
    logic [15:0]        e1_var;
    logic [1:0]         e1_tag;

    logic               e2_ready, e2_valid, e2_zero, e2_sat, e2_busy;
    logic signed [31:0] e2_mean;
    logic [15:0]        e2_var;
    logic [1:0]         e2_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ln_stat_calc_pipe dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_sum(i_sum), .i_sq_sum(i_sq_sum), .i_recip(i_recip), .i_bank_id(i_bank_id),
        .o_valid(o_valid), .i_ready(i_ready), .o_mean(o_mean), .o_variance(o_variance),
        .o_var_zero(o_var_zero), .o_var_sat(o_var_sat), .o_bank_id(o_bank_id), .o_busy(o_busy)
    );

    ln_stat_calc_pipe #(.EPS(40000)) dut_e1 (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(e1_ready),
        .i_sum(i_sum), .i_sq_sum(i_sq_sum), .i_recip(i_recip), .i_bank_id(i_bank_id),
        .o_valid(e1_valid), .i_ready(i_ready), .o_mean(e1_mean), .o_variance(e1_var),
        .o_var_zero(e1_zero), .o_var_sat(e1_sat), .o_bank_id(e1_tag), .o_busy(e1_busy)
    );

    ln_stat_calc_pipe #(.EPS(65400)) dut_e2 (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(e2_ready),
        .i_sum(i_sum), .i_sq_sum(i_sq_sum), .i_recip(i_recip), .i_bank_id(i_bank_id),
        .o_valid(e2_valid), .i_ready(i_ready), .o_mean(e2_mean), .o_variance(e2_var),
        .o_var_zero(e2_zero), .o_var_sat(e2_sat), .o_bank_id(e2_tag), .o_busy(e2_busy)
    );

    typedef struct packed {
        logic [31:0] mean;
        logic [15:0] vr;
        logic        z;
        logic        s;
        logic [1:0]  tag;
    } exp_t;

    function automatic exp_t model(input logic signed [30:0] s, input logic signed [50:0] q,
                                   input logic [11:0] r, input logic [1:0] tag);
        logic signed [127:0] ms, ex, raw, rr;
        exp_t e;
        rr     = $signed({116'd0, r});
        ms     = 128'(s) * rr;
        ms     = ms >>> 20;
        ex     = 128'(q) * rr;
        ex     = ex >>> 20;
        raw    = ex - ms * ms;
        e.mean = ms[31:0];
        e.z    = (raw < 0);
        e.s    = !e.z && (raw > 128'sd65535);
        e.vr   = e.z ? 16'd0 : (e.s ? 16'hFFFF : raw[15:0]);
        e.tag  = tag;
        return e;
    endfunction

    task automatic stream_row(input int i, output logic signed [30:0] s, output logic signed [50:0] q,
                              output logic [11:0] r, output logic [1:0] t);
        s = 31'((i - 8) * 37001);
        q = 51'(longint'(i + 1) * 2500000 + longint'(i) * 12345);
        r = (i % 2 == 1) ? 12'd2048 : 12'd1365;
        t = 2'(i);
    endtask

    // Sends one row into an idle pipeline and counts edges until o_valid shows
    task automatic send_and_time(input logic signed [30:0] s, input logic signed [50:0] q,
                                 input logic [11:0] r, input logic [1:0] t, output int lat);
        @(posedge clk); #1;
        i_valid = 1'b1; i_sum = s; i_sq_sum = q; i_recip = r; i_bank_id = t;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (o_valid) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_sum = '0; i_sq_sum = '0; i_recip = '0; i_bank_id = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_valid, o_var_zero, o_var_sat, o_busy, o_bank_id, o_variance, o_mean} !== 54'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b m=%0d var=%0d z=%b s=%b tag=%0d busy=%b exp all 0",
                     o_valid, o_mean, o_variance, o_var_zero, o_var_sat, o_bank_id, o_busy);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b exp 1", o_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        send_and_time(31'sd76800, 51'sd7680000, 12'd1365, 2'd2, lat);
        checks++;
        if (lat !== 12) begin errors++; $display("FAIL basic_latency got %0d exp 12", lat); end
        checks++;
        if (o_mean !== 32'sd99) begin errors++; $display("FAIL basic_mean got %0d exp 99", o_mean); end
        checks++;
        if (o_variance !== 16'd196) begin errors++; $display("FAIL basic_var got %0d exp 196", o_variance); end
        checks++;
        if ({o_var_zero, o_var_sat} !== 2'b00) begin
            errors++; $display("FAIL basic_flags got z=%b s=%b exp 0 0", o_var_zero, o_var_sat);
        end
        checks++;
        if (o_bank_id !== 2'd2) begin errors++; $display("FAIL basic_tag got %0d exp 2", o_bank_id); end
        checks++;
        if ({e1_valid, e1_var, e1_zero, e1_sat} !== {1'b1, 16'd40196, 2'b00}) begin
            errors++;
            $display("FAIL eps40000 got v=%b var=%0d z=%b s=%b exp v=1 var=40196 z=0 s=0",
                     e1_valid, e1_var, e1_zero, e1_sat);
        end
        checks++;
        if ({e2_valid, e2_var, e2_zero, e2_sat} !== {1'b1, 16'hFFFF, 2'b01}) begin
            errors++;
            $display("FAIL eps65400 got v=%b var=%0d z=%b s=%b exp v=1 var=65535 z=0 s=1",
                     e2_valid, e2_var, e2_zero, e2_sat);
        end
    endtask

    task automatic test_neg_floor();
        int lat;
        send_and_time(-31'sd76800, 51'sd7680000, 12'd1365, 2'd1, lat);
        checks++;
        if (lat !== 12) begin errors++; $display("FAIL neg_latency got %0d exp 12", lat); end
        checks++;
        if (o_mean !== -32'sd100) begin errors++; $display("FAIL neg_mean got %0d exp -100", o_mean); end
        checks++;
        if ({o_variance, o_var_zero, o_var_sat} !== {16'd0, 2'b10}) begin
            errors++;
            $display("FAIL neg_var got var=%0d z=%b s=%b exp var=0 z=1 s=0", o_variance, o_var_zero, o_var_sat);
        end
    endtask

    task automatic test_saturation();
        int lat;
        send_and_time(31'sd0, 51'h100_0000_0000, 12'd1365, 2'd3, lat);
        checks++;
        if (lat !== 12) begin errors++; $display("FAIL sat_latency got %0d exp 12", lat); end
        checks++;
        if ({o_mean, o_variance, o_var_zero, o_var_sat, o_bank_id} !== {32'd0, 16'hFFFF, 2'b01, 2'd3}) begin
            errors++;
            $display("FAIL sat_out got m=%0d var=%0d z=%b s=%b tag=%0d exp m=0 var=65535 z=0 s=1 tag=3",
                     o_mean, o_variance, o_var_zero, o_var_sat, o_bank_id);
        end
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        logic signed [30:0] s;
        logic signed [50:0] sq;
        logic [11:0] r;
        logic [1:0]  t;
        logic        prev_stall = 1'b0;
        logic [53:0] snap = '0;
        int idx = 0, got = 0, cyc = 0;
        while (got < 20 && cyc < 1000) begin
            @(posedge clk); #1;
            i_ready = (cyc >= 30 && cyc < 45) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (idx < 20) begin
                stream_row(idx, s, sq, r, t);
                i_valid = 1'b1; i_sum = s; i_sq_sum = sq; i_recip = r; i_bank_id = t;
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (o_ready !== !(o_valid && !i_ready)) begin
                errors++;
                $display("FAIL stream_ready cyc=%0d got %b exp %b", cyc, o_ready, !(o_valid && !i_ready));
            end
            if (prev_stall) begin
                checks++;
                if ({o_valid, o_mean, o_variance, o_var_zero, o_var_sat, o_bank_id} !== snap) begin
                    errors++;
                    $display("FAIL stream_hold cyc=%0d got %h exp %h", cyc,
                             {o_valid, o_mean, o_variance, o_var_zero, o_var_sat, o_bank_id}, snap);
                end
            end
            if (o_valid && i_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra cyc=%0d got tag=%0d exp no output", cyc, o_bank_id);
                end else begin
                    e = q.pop_front();
                    if ({o_mean, o_variance, o_var_zero, o_var_sat, o_bank_id} !== e) begin
                        errors++;
                        $display("FAIL stream_out row=%0d got m=%0d var=%0d z=%b s=%b tag=%0d exp m=%0d var=%0d z=%b s=%b tag=%0d",
                                 got, o_mean, o_variance, o_var_zero, o_var_sat, o_bank_id,
                                 $signed(e.mean), e.vr, e.z, e.s, e.tag);
                    end
                end
                got++;
            end
            prev_stall = o_valid && !i_ready;
            snap = {o_valid, o_mean, o_variance, o_var_zero, o_var_sat, o_bank_id};
            if (i_valid && o_ready) begin
                q.push_back(model(i_sum, i_sq_sum, i_recip, i_bank_id));
                idx++;
            end
            cyc++;
        end
        checks++;
        if (got != 20 || idx != 20 || q.size() != 0) begin
            errors++;
            $display("FAIL stream_count got sent=%0d recv=%0d left=%0d exp 20 20 0", idx, got, q.size());
        end
        @(posedge clk); #1;
        i_valid = 1'b0; i_ready = 1'b1;
        repeat (16) @(posedge clk);
    endtask

    task automatic test_reset_midstream();
        int lat;
        int stale = 0;
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            i_valid = 1'b1; i_sum = 31'sd76800; i_sq_sum = 51'sd7680000; i_recip = 12'd1365; i_bank_id = 2'(i);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; i_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_valid, o_var_zero, o_var_sat, o_busy, o_bank_id, o_variance, o_mean} !== 54'd0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_outputs got v=%b m=%0d var=%0d z=%b s=%b tag=%0d busy=%b rdy=%b exp zeros rdy=1",
                     o_valid, o_mean, o_variance, o_var_zero, o_var_sat, o_bank_id, o_busy, o_ready);
        end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (o_valid || o_busy) stale++;
        end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL midreset_stale got %0d cycles exp 0", stale); end
        send_and_time(31'sd76800, 51'sd7680000, 12'd1365, 2'd1, lat);
        checks++;
        if (lat !== 12) begin errors++; $display("FAIL midreset_latency got %0d exp 12", lat); end
        checks++;
        if ({o_mean, o_variance, o_var_zero, o_var_sat, o_bank_id} !== {32'd99, 16'd196, 2'b00, 2'd1}) begin
            errors++;
            $display("FAIL midreset_row got m=%0d var=%0d z=%b s=%b tag=%0d exp m=99 var=196 z=0 s=0 tag=1",
                     o_mean, o_variance, o_var_zero, o_var_sat, o_bank_id);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_floor();
        test_saturation();
        test_back_to_back();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ln_stat_calc_pipe.md
# ln_stat_calc_pipe

Parametrised LayerNorm statistics stage. It accepts a per-row sum and sum-of-squares from the accumulation stage and produces the row mean and the saturated variance (with optional epsilon) for the normalisation stage. It improves on the fixed-constant, enable-driven variance calculator in four ways: parametrised widths, a per-row reciprocal (runtime vector length), a full-width mean² subtraction, and a valid/ready handshake with back-pressure.

## Interface
Parameters:
- SUM_W, 31: signed width of i_sum.
- SQ_W, 51: signed width of i_sq_sum.
- RECIP_W, 12: unsigned width of i_recip (≈ 2^RECIP_SH / N).
- RECIP_SH, 20: arithmetic right-shift applied after the reciprocal multiply.
- MEAN_W, 32: signed width of o_mean.
- VAR_W, 16: unsigned width of o_variance.
- TAG_W, 2: width of the bank-id tag.
- EPS, 0: unsigned constant added to the variance before saturation.
- MUL_STAGES, 5: register stages per multiplier, ≥1.

Ports:
- i_clk, in, 1: the single clock.
- i_rst, in, 1: synchronous, active-high reset.
- i_valid, in, 1: input row statistics valid.
- o_ready, out, 1: block can accept input this cycle.
- i_sum, in, SUM_W: signed row sum.
- i_sq_sum, in, SQ_W: signed row sum of squares.
- i_recip, in, RECIP_W: unsigned reciprocal for this row.
- i_bank_id, in, TAG_W: tag carried with the row.
- o_valid, out, 1: result valid.
- i_ready, in, 1: downstream accepts the result.
- o_mean, out, MEAN_W: row mean.
- o_variance, out, VAR_W: saturated variance.
- o_var_zero, out, 1: variance was clamped to 0 because it was negative.
- o_var_sat, out, 1: variance was clamped to all-ones.
- o_bank_id, out, TAG_W: tag of the result.
- o_busy, out, 1: any valid row is in the pipeline or at the output.

## Operation
- Arithmetic uses exact widths, with no intermediate truncation.
- mean_f = (i_sum × i_recip) >>> RECIP_SH. The product is signed and i_recip is zero-extended. The shift is arithmetic (floor).
- ex2 = (i_sq_sum × i_recip) >>> RECIP_SH, at full product width.
- msq = mean_f × mean_f, at full 2× width.
- raw = ex2 − msq + EPS, computed signed and wide enough to never overflow.
- If raw < 0: o_variance = 0 and o_var_zero = 1.
- Else if raw > 2^VAR_W − 1: o_variance = all-ones and o_var_sat = 1.
- Otherwise o_variance = raw[VAR_W−1:0]; both flags are 0.
- o_mean = mean_f, sign-extended or truncated to MEAN_W (low bits).
- i_recip and i_bank_id travel with the row through every stage. Rows with different recip values may be interleaved back-to-back.
- Pipeline: multiply (MUL_STAGES) → shift reg (1) → square (MUL_STAGES) → subtract/EPS/saturate reg (1) → output reg. Every stage carries a valid bit.
- Advance: en = ~o_valid | i_ready, and o_ready = en. All stages hold when en = 0. There is no data loss and no duplication.
- An input is accepted when i_valid & o_ready at a clock edge.
- An output is consumed when o_valid & i_ready at a clock edge.
- o_busy = OR of all stage valid bits and o_valid.
- Reset clears all valid bits and drives every output to 0: o_valid, o_mean, o_variance, o_var_zero, o_var_sat, o_bank_id, o_busy.
- Rows in flight at reset are discarded.
- Reset has priority over i_valid in the same cycle.

## Timing
- Latency L = 2·MUL_STAGES + 2 (12 at defaults), counted in en-high cycles.
- A row accepted at edge t appears with o_valid high after edge t+L when there is no stall.
- Throughput is 1 row per cycle while i_ready = 1.
- The output holds stable while o_valid & ~i_ready.
- While stalled, o_ready is low in the same cycle; it is purely combinational from o_valid and i_ready.
- o_ready = 1 in the first cycle after reset is released.
- An accept and a consume in the same cycle are both honoured.
- o_valid and the flags update only on en; they are not pulsed.

## Test plan
- Basic row: sum = 76800, sq_sum = 7680000, recip = 1365, tag = 2.
  - Required: o_mean = 99, o_variance = 196, both flags 0, o_bank_id = 2.
  - o_valid must rise exactly 12 cycles after accept.
- Negative mean floor: sum = −76800, sq_sum = 7680000, recip = 1365.
  - Required: o_mean = −100, raw = −3, o_variance = 0, o_var_zero = 1.
- Saturation: sum = 0, sq_sum = 2^40, recip = 1365.
  - Required: o_variance = 65535, o_var_sat = 1.
  - Repeat the basic row with EPS = 40000: o_variance = 40196. With EPS = 65400: saturated.
- Back-pressure: stream 20 rows with distinct tags and recips (1365 and 2048 alternating). Toggle i_ready randomly, including holding it low for 15 cycles.
  - Required: outputs are in order, none lost or duplicated, and each matches the model.
  - o_ready is low exactly when o_valid & ~i_ready.
- Reset mid-stream: assert i_rst for 1 cycle with 6 rows in flight.
  - Required: all outputs are 0 the next cycle, no stale row ever emerges, and o_busy = 0.
  - A row accepted after reset completes normally with L = 12.
